// File: rtl/booth_mult_scheduler.sv
// Two-requester scheduler for a shared radix-4 Booth multiplier that retires one digit per cycle.
// Requesters are arbitrated round-robin, and each result is held until the consumer takes it.
module booth_mult_scheduler #(
  parameter int MAN_W = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [MAN_W-1:0]     req0_a,
  input  logic [MAN_W-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [MAN_W-1:0]     req1_a,
  input  logic [MAN_W-1:0]     req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*MAN_W-1:0]   res_product,
  output logic                 res_id,
  output logic                 busy
);

  localparam int ACC_W  = 2*MAN_W + 2;
  localparam int BEXT_W = MAN_W + 2;
  localparam int NDIG   = BEXT_W / 2;
  localparam int CNT_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                    state_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   mcand_reg;
  logic signed [ACC_W-1:0]   pp;
  logic [BEXT_W-1:0]         bsh_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic                      id_reg;
  logic                      last_served_reg;
  logic [1:0]                valid_vec;
  logic [1:0]                ready_vec;
  logic                      grant;
  logic                      accept;
  logic [MAN_W-1:0]          sel_a;
  logic [MAN_W-1:0]          sel_b;

  assign valid_vec = {req1_valid, req0_valid};

  // On a tie the requester that was not served last wins.
  assign grant = (valid_vec == 2'b11) ? ~last_served_reg : valid_vec[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == IDLE) && valid_vec[gi] && (grant == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;
  assign sel_a      = grant ? req1_a : req0_a;
  assign sel_b      = grant ? req1_b : req0_b;
  assign busy       = (state_reg != IDLE);

  // The low three bits of the shifted multiplier form the current Booth digit.
  always_comb begin
    pp = '0;
    case (bsh_reg[2:0])
      3'b001, 3'b010: pp = mcand_reg;
      3'b011:         pp = mcand_reg <<< 1;
      3'b100:         pp = -(mcand_reg <<< 1);
      3'b101, 3'b110: pp = -mcand_reg;
      default:        pp = '0;
    endcase
    acc_next = acc_reg + pp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      acc_reg         <= '0;
      mcand_reg       <= '0;
      bsh_reg         <= '0;
      cnt_reg         <= '0;
      id_reg          <= 1'b0;
      last_served_reg <= 1'b1;
      res_valid       <= 1'b0;
      res_product     <= '0;
      res_id          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mcand_reg       <= ACC_W'(sel_a);
            bsh_reg         <= {1'b0, sel_b, 1'b0};
            acc_reg         <= '0;
            cnt_reg         <= '0;
            id_reg          <= grant;
            last_served_reg <= grant;
            state_reg       <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          mcand_reg <= mcand_reg <<< 2;
          bsh_reg   <= bsh_reg >> 2;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(NDIG-1)) begin
            state_reg   <= HOLD;
            res_valid   <= 1'b1;
            res_product <= acc_next[2*MAN_W-1:0];
            res_id      <= id_reg;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_reg <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
